// File: rtl/acum_ctrl_if.sv
// Bus between the accumulator sequencer and its selector/multiplier neighbours.
// The master side requests samples and supplies data; the slave side runs the accumulation.
interface acum_ctrl_if #(
   parameter int WIDTH = 25,
   parameter int CNT_W = 3
);
   logic             start;
   logic [WIDTH-1:0] mux_out;
   logic [WIDTH-1:0] term;
   logic             sel;
   logic [WIDTH-1:0] acum;
   logic [CNT_W-1:0] term_idx;
   logic [WIDTH-1:0] yk;
   logic             busy;
   logic             done;
   logic             ovf;

   modport master (
      output start, mux_out, term,
      input  sel, acum, term_idx, yk, busy, done, ovf
   );

   modport slave (
      input  start, mux_out, term,
      output sel, acum, term_idx, yk, busy, done, ovf
   );
endinterface

// File: rtl/acum_ctrl.sv
// Accumulator sequencer: sums N_TERMS saturated product terms per sample,
// driving the uk/accumulator selector and publishing yk with a done strobe.
module acum_ctrl #(
   parameter int WIDTH   = 25,
   parameter int N_TERMS = 5,
   parameter int CNT_W   = 3
) (
   input  logic        clk,
   input  logic        reset,
   acum_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_TERMS - 1);
   localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acum_q, yk_q;
   logic [CNT_W-1:0] idx_q;
   logic             ovf_q, sticky_q;

   logic [WIDTH:0]   sum;
   logic             clamp;
   logic [WIDTH-1:0] sat;
   logic             sel, busy, done;

   // One guard bit: the top two bits disagree exactly when the sum left the signed range.
   always_comb begin
      sum   = {bus.mux_out[WIDTH-1], bus.mux_out} + {bus.term[WIDTH-1], bus.term};
      clamp = sum[WIDTH] ^ sum[WIDTH-1];
      sat   = sum[WIDTH-1:0];
      if (clamp) sat = sum[WIDTH] ? S_MIN : S_MAX;
   end

   always_comb begin
      state_d = state_q;
      sel     = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: if (bus.start) state_d = ACC;
         ACC: begin
            busy = 1'b1;
            sel  = (idx_q != '0);
            if (idx_q == LAST) state_d = OUT;
         end
         OUT: begin
            done    = 1'b1;
            state_d = bus.start ? ACC : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         acum_q   <= '0;
         yk_q     <= '0;
         idx_q    <= '0;
         ovf_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE, OUT: begin
               if (bus.start) begin
                  idx_q    <= '0;
                  sticky_q <= 1'b0;
               end
            end
            ACC: begin
               acum_q <= sat;
               if (idx_q == LAST) begin
                  yk_q     <= sat;
                  ovf_q    <= sticky_q | clamp;
                  idx_q    <= '0;
                  sticky_q <= sticky_q | clamp;
               end else begin
                  idx_q    <= idx_q + 1'b1;
                  sticky_q <= sticky_q | clamp;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sel      = sel;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.acum     = acum_q;
   assign bus.yk       = yk_q;
   assign bus.term_idx = idx_q;
   assign bus.ovf      = ovf_q;

endmodule
